fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage of the 5-stage RISC-V pipeline. Holds the PC and issues one word read per cycle to a synchronous instruction memory with a fixed 1-cycle latency. Buffers returned words in a 2-entry FIFO so decode stalls never lose data. Drives the `fe_to_de_s` register consumed by decode, and handles redirects (branches and jumps) from execute with an epoch-based squash.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `NOP_INSTR`, default 32'h0000_0013: instruction_value driven in bubbles.

Ports:
- `clk`  in  1  sole clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `stall_f`  in  1  hazard unit: hold `fe_to_de` unchanged this cycle.
- `pc_r`  in  1  redirect request from execute (taken branch/jump).
- `pc_target`  in  32  redirect target; bits [1:0] ignored (forced 2'b00).
- `imem_en`  out  1  read request this cycle.
- `imem_addr`  out  32  word-aligned byte address of the request.
- `imem_rdata`  in  32  read data; valid the cycle after `imem_en`.
- `fe_to_de`  out  `fe_to_de_s`  registered {pc_value, instruction_value, pc_r}; `fe_to_de.pc_r`=1 marks a bubble/squashed slot.

## Operation
- State: `pc` (32), `epoch` (1), in-flight record {valid, pc, epoch}, 2-entry FIFO of {pc, instr}, output register `fe_to_de`.
- occupancy = fifo_count + inflight_valid, range 0..2.
- Issue: `imem_en` = !rst && !pc_r && !(stall_f && occupancy==2). `imem_addr` = `pc`. On issue: record {1, pc, epoch} as in-flight and set pc <= pc+4, which wraps modulo 2^32.
- Response: arrives the cycle after an issue. It is accepted only if its recorded epoch == current epoch and no redirect occurs this cycle; otherwise it is dropped.
- Output load, when !stall_f:
  - FIFO non-empty: load the head and pop it; an accepted response is pushed in the same cycle.
  - FIFO empty and response accepted: bypass the response directly into `fe_to_de`.
  - Neither: load a bubble {pc_value=0, instruction_value=NOP_INSTR, pc_r=1}.
  - Every valid load sets `fe_to_de.pc_r`=0.
- With stall_f=1, `fe_to_de` holds its value and an accepted response is pushed into the FIFO. The FIFO must never overflow; the issue rule guarantees this, and the bench asserts it.
- Redirect (pc_r=1): overrides stall_f.
  - pc <= {pc_target[31:2],2'b00}; epoch toggles.
  - FIFO flushed; in-flight data discarded.
  - `fe_to_de` <= bubble; no issue this cycle.
- Back-to-back redirects: the last one wins; each toggles the epoch.
- Reset (any cycle, including mid-stall or with a request in flight):
  - pc <= RESET_PC; epoch <= 0; FIFO emptied; inflight_valid <= 0.
  - `fe_to_de` <= bubble; `imem_en`=0 during reset.
  - A response arriving the cycle after reset is dropped because inflight_valid=0.
- Fetched instruction contents are not interpreted.

## Timing
- Reset values: `fe_to_de`={0, NOP_INSTR, pc_r=1}; `imem_en`=0; `imem_addr`=RESET_PC.
- Startup: first cycle with rst=0 (cycle 0) issues RESET_PC. Data arrives in cycle 1 and is bypassed at the end of cycle 1. `fe_to_de` shows RESET_PC valid in cycle 2.
- Steady state: 1 instruction/cycle with consecutive pc_value +4.
- Redirect penalty: pc_r in cycle R, target issued in R+1, target visible in `fe_to_de` in R+3. Cycles R+1 and R+2 show bubbles.
- Stall: `fe_to_de` constant while stall_f=1. At most 2 words are buffered. When the stall releases, buffered words drain one per cycle in program order with no gap and no duplicate.
- Response-to-output latency is 1 cycle via bypass, or FIFO depth + 1 when buffered.

## Test plan
- Reset then 8 free-running cycles, imem returning word = address: `fe_to_de` shows a bubble, a bubble, then pc 0,4,8,… with instruction_value equal to pc and pc_r=0.
- stall_f high for 5 cycles mid-stream at pc=0x10: output holds 0x10. imem_en drops once occupancy=2. After release, the output continues 0x14, 0x18, 0x1C with no gaps or duplicates.
- pc_r=1 with pc_target=0x103 while a request for 0x20 is in flight: 0x20 is dropped. Two bubbles follow, then pc_value=0x100.
- Redirect asserted simultaneously with stall_f=1 and a full FIFO: next cycle is a bubble, the FIFO is empty, and the 0x200 target appears 3 cycles after the redirect.
- Back-to-back pc_r to 0x40 then 0x80: no word from 0x40 is ever emitted; the first valid output is 0x80.
- rst asserted for 1 cycle mid-stall with a full FIFO: all state is cleared and the stream restarts at RESET_PC. With pc near 0xFFFF_FFF8, the stream wraps through 0xFFFF_FFFC to 0x0.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Shared types and the instruction-memory bus for the fetch stage.
// The package carries the fetch-to-decode record so that the stage and its
// consumers agree on one layout. The interface groups the synchronous
// instruction-memory read port: request and address from fetch, data back
// one cycle later.

package fetch_stage_pkg;

  // Record handed from fetch to decode; pc_r=1 marks a bubble or squashed slot.
  typedef struct packed {
    logic [31:0] pc_value;
    logic [31:0] instruction_value;
    logic        pc_r;
  } fe_to_de_s;

endpackage

interface fetch_stage_if;

  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;

  // Fetch side: issues requests, consumes read data.
  modport master (
    output imem_en,
    output imem_addr,
    input  imem_rdata
  );

  // Memory side: accepts requests, returns read data one cycle later.
  modport slave (
    input  imem_en,
    input  imem_addr,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage of the 5-stage RISC-V pipeline.
// Holds the PC, issues one word read per cycle to a 1-cycle-latency memory,
// buffers returned words in a 2-entry FIFO so decode stalls never lose data,
// and squashes stale responses after a redirect using a 1-bit epoch.
// Occupancy (FIFO entries plus the in-flight read) is capped at 2 by only
// withholding issue while stalled and full, so the FIFO cannot overflow.

module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall_f,
  input  logic                pc_r,
  input  logic [31:0]         pc_target,
  fetch_stage_if.master       imem,
  output fe_to_de_s           fe_to_de
);

  localparam fe_to_de_s BUBBLE = '{
    pc_value:          32'h0000_0000,
    instruction_value: NOP_INSTR,
    pc_r:              1'b1
  };

  // Architectural fetch state.
  logic [31:0] fetch_pc_r;
  logic        epoch_r;

  // Record of the read issued last cycle, whose data arrives this cycle.
  logic        infl_valid_r;
  logic [31:0] infl_pc_r;
  logic        infl_epoch_r;

  // Two-entry word buffer used while decode is stalled.
  logic [31:0] fifo_pc_r    [2];
  logic [31:0] fifo_instr_r [2];
  logic        fifo_rd_ptr_r;
  logic        fifo_wr_ptr_r;
  logic [1:0]  fifo_count_r;

  // Registered output slot.
  fe_to_de_s   fe_out_r;

  // Combinational control.
  logic [1:0]  occupancy_s;
  logic        fifo_empty_s;
  logic        issue_s;
  logic        resp_accept_s;
  logic        fifo_push_s;
  logic        fifo_pop_s;
  logic [31:0] redirect_pc_s;
  fe_to_de_s   fifo_head_s;

  // Issue, accept, push and pop decisions for this cycle.
  always_comb begin
    occupancy_s   = 2'd0;
    fifo_empty_s  = 1'b1;
    issue_s       = 1'b0;
    resp_accept_s = 1'b0;
    fifo_push_s   = 1'b0;
    fifo_pop_s    = 1'b0;
    redirect_pc_s = pc_target & 32'hFFFF_FFFC;

    occupancy_s  = fifo_count_r + {1'b0, infl_valid_r};
    fifo_empty_s = (fifo_count_r == 2'd0);

    // Withhold issue only when stalled with two words already owed.
    if (!rst && !pc_r && !(stall_f && (occupancy_s == 2'd2))) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end

    // A response is kept only if it belongs to the current epoch and no
    // redirect squashes it in the very cycle it arrives.
    if (!rst && !pc_r && infl_valid_r && (infl_epoch_r == epoch_r)) begin
      resp_accept_s = 1'b1;
    end else begin
      resp_accept_s = 1'b0;
    end

    if (!rst && !pc_r && !stall_f && !fifo_empty_s) begin
      fifo_pop_s = 1'b1;
    end else begin
      fifo_pop_s = 1'b0;
    end

    // Bypass straight to the output when decode is free and nothing queued.
    if (resp_accept_s && (stall_f || !fifo_empty_s)) begin
      fifo_push_s = 1'b1;
    end else begin
      fifo_push_s = 1'b0;
    end
  end

  // Head-of-FIFO view as a ready-to-load output record.
  always_comb begin
    fifo_head_s                   = BUBBLE;
    fifo_head_s.pc_value          = fifo_pc_r[fifo_rd_ptr_r];
    fifo_head_s.instruction_value = fifo_instr_r[fifo_rd_ptr_r];
    fifo_head_s.pc_r              = 1'b0;
  end

  // PC and epoch: reset, redirect (toggles epoch), or advance on issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_r <= RESET_PC;
      epoch_r    <= 1'b0;
    end else if (pc_r) begin
      fetch_pc_r <= redirect_pc_s;
      epoch_r    <= ~epoch_r;
    end else if (issue_s) begin
      fetch_pc_r <= fetch_pc_r + 32'd4;
      epoch_r    <= epoch_r;
    end else begin
      fetch_pc_r <= fetch_pc_r;
      epoch_r    <= epoch_r;
    end
  end

  // In-flight record for the read issued this cycle.
  always_ff @(posedge clk) begin
    if (rst || pc_r) begin
      infl_valid_r <= 1'b0;
      infl_pc_r    <= 32'h0000_0000;
      infl_epoch_r <= 1'b0;
    end else if (issue_s) begin
      infl_valid_r <= 1'b1;
      infl_pc_r    <= fetch_pc_r;
      infl_epoch_r <= epoch_r;
    end else begin
      infl_valid_r <= 1'b0;
      infl_pc_r    <= infl_pc_r;
      infl_epoch_r <= infl_epoch_r;
    end
  end

  // FIFO storage: write the accepted response at the write pointer.
  always_ff @(posedge clk) begin
    if (fifo_push_s) begin
      fifo_pc_r[fifo_wr_ptr_r]    <= infl_pc_r;
      fifo_instr_r[fifo_wr_ptr_r] <= imem.imem_rdata;
    end else begin
      fifo_pc_r[fifo_wr_ptr_r]    <= fifo_pc_r[fifo_wr_ptr_r];
      fifo_instr_r[fifo_wr_ptr_r] <= fifo_instr_r[fifo_wr_ptr_r];
    end
  end

  // FIFO pointers and count; reset and redirect flush everything.
  always_ff @(posedge clk) begin
    if (rst || pc_r) begin
      fifo_rd_ptr_r <= 1'b0;
      fifo_wr_ptr_r <= 1'b0;
      fifo_count_r  <= 2'd0;
    end else begin
      fifo_rd_ptr_r <= fifo_rd_ptr_r ^ fifo_pop_s;
      fifo_wr_ptr_r <= fifo_wr_ptr_r ^ fifo_push_s;
      fifo_count_r  <= fifo_count_r + {1'b0, fifo_push_s} - {1'b0, fifo_pop_s};
    end
  end

  // Output slot: bubble on reset/redirect, hold on stall, else FIFO head,
  // bypassed response, or bubble when nothing is available.
  always_ff @(posedge clk) begin
    if (rst) begin
      fe_out_r <= BUBBLE;
    end else if (pc_r) begin
      fe_out_r <= BUBBLE;
    end else if (stall_f) begin
      fe_out_r <= fe_out_r;
    end else if (!fifo_empty_s) begin
      fe_out_r <= fifo_head_s;
    end else if (resp_accept_s) begin
      fe_out_r <= '{pc_value: infl_pc_r, instruction_value: imem.imem_rdata, pc_r: 1'b0};
    end else begin
      fe_out_r <= BUBBLE;
    end
  end

  assign imem.imem_en   = issue_s;
  assign imem.imem_addr = fetch_pc_r;
  assign fe_to_de       = fe_out_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage. A queue-based model tracks the words
// the stage owes decode; directed scenarios check the documented timing with
// literal values, and a randomized run compares every cycle against the model.

module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        stall_f;
  logic        pc_r;
  logic [31:0] pc_target;
  fe_to_de_s   fe_to_de;

  fetch_stage_if bus ();

  fetch_stage #(
    .RESET_PC  (RESET_PC),
    .NOP_INSTR (NOP_INSTR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .stall_f   (stall_f),
    .pc_r      (pc_r),
    .pc_target (pc_target),
    .imem      (bus),
    .fe_to_de  (fe_to_de)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] key      = 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory: word = address ^ key; garbage when not read.
  always @(posedge clk) begin
    if (bus.imem_en) bus.imem_rdata <= bus.imem_addr ^ key;
    else             bus.imem_rdata <= $urandom;
  end

  // Reference model: queue of words owed to decode, in program order.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } word_t;

  word_t       q[$];
  logic [31:0] m_pc  = RESET_PC;
  fe_to_de_s   m_out;
  logic        exp_en;
  logic [31:0] exp_addr;
  logic        obs_en;
  logic [31:0] obs_addr;

  function automatic fe_to_de_s bubble();
    fe_to_de_s b;
    b.pc_value = 32'h0; b.instruction_value = NOP_INSTR; b.pc_r = 1'b1;
    return b;
  endfunction

  function automatic fe_to_de_s valid_word(input logic [31:0] pc);
    fe_to_de_s v;
    v.pc_value = pc; v.instruction_value = pc ^ key; v.pc_r = 1'b0;
    return v;
  endfunction

  // One clock cycle: drive inputs, sample the request mid-cycle, advance model.
  task automatic step(input bit r, input bit s, input bit d, input logic [31:0] t);
    word_t w;
    rst = r; stall_f = s; pc_r = d; pc_target = t;
    @(negedge clk);
    obs_en   = bus.imem_en;
    obs_addr = bus.imem_addr;
    exp_en   = !r && !d && !(s && q.size() == 2);
    exp_addr = m_pc;
    @(posedge clk);
    if (r) begin
      m_pc = RESET_PC; q.delete(); m_out = bubble();
    end else if (d) begin
      m_pc = t & 32'hFFFF_FFFC; q.delete(); m_out = bubble();
    end else begin
      if (!s) begin
        if (q.size() > 0) begin
          w = q.pop_front();
          m_out.pc_value = w.pc; m_out.instruction_value = w.instr; m_out.pc_r = 1'b0;
        end else begin
          m_out = bubble();
        end
      end
      if (exp_en) begin
        w.pc = m_pc; w.instr = m_pc ^ key;
        q.push_back(w);
        m_pc = m_pc + 32'd4;
      end
    end
    #1;
  endtask

  // Free-run until a valid output with the given pc appears (bounded).
  task automatic run_until(input logic [31:0] pc, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (fe_to_de.pc_r === 1'b0 && fe_to_de.pc_value === pc) begin
        ok = 1'b1;
        break;
      end
      step(1'b0, 1'b0, 1'b0, 32'h0);
    end
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (fe_to_de !== bubble()) begin
      n_fail++; $display("FAIL reset_out got=%h exp=%h", fe_to_de, bubble());
    end
    n_checks++;
    if (obs_en !== 1'b0) begin
      n_fail++; $display("FAIL reset_en got=%b exp=0", obs_en);
    end
    n_checks++;
    if (obs_addr !== RESET_PC) begin
      n_fail++; $display("FAIL reset_addr got=%h exp=%h", obs_addr, RESET_PC);
    end
  endtask

  task automatic test_startup();
    fe_to_de_s e;
    key = 32'h0;
    step(1'b1, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      e = (k == 0) ? bubble() : valid_word(32'(4 * (k - 1)));
      n_checks++;
      if (fe_to_de !== e) begin
        n_fail++; $display("FAIL startup k=%0d got=%h exp=%h", k, fe_to_de, e);
      end
      n_checks++;
      if (obs_en !== 1'b1 || obs_addr !== 32'(4 * k)) begin
        n_fail++; $display("FAIL startup_req k=%0d got=%b/%h exp=1/%h", k, obs_en, obs_addr, 32'(4 * k));
      end
    end
  endtask

  task automatic test_stall();
    bit ok;
    int en_low;
    key = 32'h5A5A_0000;
    step(1'b1, 1'b0, 1'b0, 32'h0);
    run_until(32'h10, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL stall_reach got=timeout exp=pc10"); end
    en_low = 0;
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0);
      if (!obs_en) en_low++;
      n_checks++;
      if (fe_to_de !== valid_word(32'h10)) begin
        n_fail++; $display("FAIL stall_hold k=%0d got=%h exp=%h", k, fe_to_de, valid_word(32'h10));
      end
    end
    n_checks++;
    if (en_low != 4) begin n_fail++; $display("FAIL stall_en_low got=%0d exp=4", en_low); end
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      n_checks++;
      if (fe_to_de !== valid_word(32'h14 + 32'(4 * k))) begin
        n_fail++; $display("FAIL stall_drain k=%0d got=%h exp=%h", k, fe_to_de, valid_word(32'h14 + 32'(4 * k)));
      end
    end
  endtask

  task automatic test_redirect();
    bit ok;
    fe_to_de_s e[4];
    key = $urandom;
    step(1'b1, 1'b0, 1'b0, 32'h0);
    run_until(32'h1C, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL redir_reach got=timeout exp=pc1c"); end
    e[0] = bubble(); e[1] = bubble(); e[2] = valid_word(32'h100); e[3] = valid_word(32'h104);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, (k == 0), 32'h103);
      n_checks++;
      if (fe_to_de !== e[k]) begin
        n_fail++; $display("FAIL redir k=%0d got=%h exp=%h", k, fe_to_de, e[k]);
      end
    end
  endtask

  task automatic test_redirect_stall_full();
    bit ok;
    fe_to_de_s e[3];
    key = $urandom;
    step(1'b1, 1'b0, 1'b0, 32'h0);
    run_until(32'h8, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL rsf_reach got=timeout exp=pc8"); end
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 32'h0);
    e[0] = bubble(); e[1] = bubble(); e[2] = valid_word(32'h200);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, (k == 0), (k == 0), 32'h200);
      if (k == 0) begin
        n_checks++;
        if (dut.fifo_count_r !== 2'd0) begin
          n_fail++; $display("FAIL rsf_flush got=%0d exp=0", dut.fifo_count_r);
        end
      end
      n_checks++;
      if (fe_to_de !== e[k]) begin
        n_fail++; $display("FAIL rsf k=%0d got=%h exp=%h", k, fe_to_de, e[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] first_pc;
    bit          seen;
    key = $urandom;
    step(1'b1, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h40);
    step(1'b0, 1'b0, 1'b1, 32'h80);
    seen = 1'b0; first_pc = 32'h0;
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      if (fe_to_de.pc_r === 1'b0) begin
        if (!seen) first_pc = fe_to_de.pc_value;
        seen = 1'b1;
        n_checks++;
        if (fe_to_de.pc_value >= 32'h40 && fe_to_de.pc_value < 32'h80) begin
          n_fail++; $display("FAIL b2b_stale got=%h exp=>=80", fe_to_de.pc_value);
        end
      end
    end
    n_checks++;
    if (!seen || first_pc !== 32'h80) begin
      n_fail++; $display("FAIL b2b_first got=%h exp=00000080", first_pc);
    end
  endtask

  task automatic test_reset_mid_stall_and_wrap();
    bit ok;
    logic [31:0] exp_seq[4];
    int          idx;
    key = $urandom;
    step(1'b1, 1'b0, 1'b0, 32'h0);
    run_until(32'hC, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL rms_reach got=timeout exp=pcc"); end
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    n_checks++;
    if (fe_to_de !== bubble() || dut.fifo_count_r !== 2'd0) begin
      n_fail++; $display("FAIL rms_clear got=%h/%0d exp=%h/0", fe_to_de, dut.fifo_count_r, bubble());
    end
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (fe_to_de !== valid_word(RESET_PC)) begin
      n_fail++; $display("FAIL rms_restart got=%h exp=%h", fe_to_de, valid_word(RESET_PC));
    end
    exp_seq[0] = 32'hFFFF_FFF8; exp_seq[1] = 32'hFFFF_FFFC; exp_seq[2] = 32'h0; exp_seq[3] = 32'h4;
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8);
    idx = 0;
    for (int k = 0; k < 8 && idx < 4; k++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      if (fe_to_de.pc_r === 1'b0) begin
        n_checks++;
        if (fe_to_de !== valid_word(exp_seq[idx])) begin
          n_fail++; $display("FAIL wrap i=%0d got=%h exp=%h", idx, fe_to_de, valid_word(exp_seq[idx]));
        end
        idx++;
      end
    end
    n_checks++;
    if (idx != 4) begin n_fail++; $display("FAIL wrap_count got=%0d exp=4", idx); end
  endtask

  task automatic test_random();
    bit r, s, d;
    key = $urandom;
    step(1'b1, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 600; k++) begin
      r = ($urandom_range(99) < 2);
      s = ($urandom_range(99) < 30);
      d = ($urandom_range(99) < 6);
      step(r, s, d, $urandom);
      n_checks++;
      if (fe_to_de !== m_out) begin
        n_fail++; $display("FAIL rand_out k=%0d got=%h exp=%h", k, fe_to_de, m_out);
      end
      n_checks++;
      if (obs_en !== exp_en || (exp_en && obs_addr !== exp_addr)) begin
        n_fail++; $display("FAIL rand_req k=%0d got=%b/%h exp=%b/%h", k, obs_en, obs_addr, exp_en, exp_addr);
      end
      n_checks++;
      if (dut.fifo_count_r > 2'd2) begin
        n_fail++; $display("FAIL rand_overflow k=%0d got=%0d exp=<=2", k, dut.fifo_count_r);
      end
    end
  endtask

  initial begin
    rst = 1'b1; stall_f = 1'b0; pc_r = 1'b0; pc_target = 32'h0;
    m_out = bubble();
    test_reset();
    test_startup();
    test_stall();
    test_redirect();
    test_redirect_stall_full();
    test_back_to_back();
    test_reset_mid_stall_and_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
